// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter byte interface between NUM_REQ byte-message
// sources. Arbitration happens once per message: the winning source keeps
// the transmitter until it hands over a byte flagged as last, or until it
// stays silent for TIMEOUT_CYC cycles in the middle of a message, in which
// case the message is aborted. An optional gap of GAP_CYC idle cycles
// follows every completed message before the next arbitration.
//
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin between messages
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   req       per-source byte valid
//   req_data  byte of source i on [8i+7:8i]
//   req_last  marks the presented byte as the final one of its message
//   req_ack   one-cycle pulse: byte of source i accepted by the transmitter
//   tx_data   byte to the UART transmitter
//   tx_valid  tx_data valid
//   tx_ready  transmitter can take a byte
//   grant_id  current / most recently granted source
//   busy      high whenever the arbiter is not idle
//   abort     one-cycle pulse when a locked message times out
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_REQ-1:0]                               req,
    input  logic [8*NUM_REQ-1:0]                             req_data,
    input  logic [NUM_REQ-1:0]                               req_last,
    output logic [NUM_REQ-1:0]                               req_ack,
    output logic [7:0]                                       tx_data,
    output logic                                             tx_valid,
    input  logic                                             tx_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                             busy,
    output logic                                             abort
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);
    localparam logic [GCW-1:0] GAP_LAST     = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IDW:0]   NUM_REQ_W    = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID      = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        NEXT,
        GAP
    } stateT;

    stateT           state;
    logic [IDW-1:0]  rrPtr;
    logic            lastQ;
    logic            nextArmed;   // low during the first NEXT cycle
    logic [TCW-1:0]  timeoutCnt;
    logic [GCW-1:0]  gapCnt;

    logic [7:0]      reqByte [NUM_REQ];
    logic [IDW:0]    candSum [NUM_REQ];
    logic [IDW-1:0]  candIdx [NUM_REQ];
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  rrPtrAdv;

    // Per-source byte lanes and the rotated scan order starting at rrPtr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign reqByte[gi] = req_data[8*gi +: 8];
            assign candSum[gi] = {1'b0, rrPtr} + (IDW + 1)'(gi);
            assign candIdx[gi] = (candSum[gi] >= NUM_REQ_W) ? IDW'(candSum[gi] - NUM_REQ_W)
                                                            : IDW'(candSum[gi]);
        end
    endgenerate

    // Scan from the farthest candidate back to rrPtr so the nearest set
    // request after rrPtr is the one left in winner. With rrPtr pinned at 0
    // this is plain lowest-index priority.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[candIdx[k]]) begin
                winner = candIdx[k];
            end
        end
    end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign rrPtrAdv = '0;
`else
    assign rrPtrAdv = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= '0;
            lastQ      <= 1'b0;
            nextArmed  <= 1'b0;
            timeoutCnt <= '0;
            gapCnt     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            req_ack    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            req_ack <= '0;
            abort   <= 1'b0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        tx_data  <= reqByte[winner];
                        lastQ    <= req_last[winner];
                        grant_id <= winner;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid          <= 1'b0;
                        req_ack[grant_id] <= 1'b1;
                        if (lastQ) begin
                            rrPtr <= rrPtrAdv;
                            if (GAP_CYC > 0) begin
                                gapCnt <= '0;
                                state  <= GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            timeoutCnt <= '0;
                            nextArmed  <= 1'b0;
                            state      <= NEXT;
                        end
                    end
                end

                NEXT: begin
                    // The source still shows the just-acked byte during the
                    // ack cycle, so the first NEXT cycle never accepts.
                    if (nextArmed && req[grant_id]) begin
                        tx_data  <= reqByte[grant_id];
                        lastQ    <= req_last[grant_id];
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end else if (timeoutCnt == TIMEOUT_LAST) begin
                        abort <= 1'b1;
                        rrPtr <= rrPtrAdv;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                        nextArmed  <= 1'b1;
                    end
                end

                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between several byte-message sources: RX echo, rate/status report, FINISH notice, and spares.
- Round-robin arbitration at message granularity. A granted source keeps the transmitter until it sends its last byte or goes silent past a timeout.
- Sits between the message sources and the UART TX byte interface (valid/ready). The transmitter raises ready when it can accept a new byte.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 1024, idle cycles tolerated inside a locked message before abort (>=2).
- GAP_CYC, 0, idle cycles inserted after each completed message before re-arbitration (0 = none).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-source byte-valid
- req_data  in  8*NUM_REQ  byte for source i at [8i+7:8i]
- req_last  in  NUM_REQ  qualifies the byte as the final one of the message
- req_ack  out  NUM_REQ  one-cycle pulse: byte of source i accepted by TX
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX can take a byte
- grant_id  out  clog2(NUM_REQ) (min 1)  current/last granted source
- busy  out  1  high in any state other than IDLE
- abort  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, active-high):
  - state=IDLE; rr_ptr=0; tx_data=0; tx_valid=0; req_ack=0; grant_id=0; busy=0; abort=0; counters=0.
- All outputs are registered.
- States: IDLE, SEND, NEXT, GAP.
- IDLE:
  - If any req bit is set, pick the winner: first set bit scanning from rr_ptr upward, with wrap-around.
  - In the same edge, latch tx_data=req_data[winner], last_q=req_last[winner], grant_id=winner, tx_valid=1; go SEND.
  - Latency: req sampled high at edge n gives tx_valid high after edge n.
- SEND:
  - Hold tx_valid and tx_data stable until tx_valid&&tx_ready.
  - On that handshake: tx_valid=0 and req_ack[grant_id]=1 for exactly one cycle.
  - If last_q=1: rr_ptr=(grant_id+1) mod NUM_REQ; go GAP if GAP_CYC>0, else IDLE.
  - Otherwise go NEXT and clear the timeout counter.
  - tx_ready high while tx_valid is low has no effect.
- NEXT (locked to grant_id; other requesters are ignored):
  - The source removes the acked byte on the ack cycle and may present the next byte from the following cycle.
  - NEXT ignores req[grant_id] in its first cycle, so a stale byte is never double-sent.
  - From the second cycle on, req[grant_id]=1 latches the byte and last flag, sets tx_valid=1, and goes SEND.
  - Each cycle without req increments the timeout counter. At TIMEOUT_CYC: abort=1 for one cycle, rr_ptr=grant_id+1 mod NUM_REQ, go IDLE. No byte is sent and no ack is given.
- GAP: count GAP_CYC cycles with busy=1, then go IDLE.
- req_data and req_last of non-granted sources are don't-care.
- A source deasserting req while in SEND has no effect: the latched byte is still sent and acked.
- Simultaneous requests: only one winner per arbitration. Losers wait with req held and get no ack.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-message: the message is dropped. The source sees no ack and must restart the message.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins in IDLE; rr_ptr is held at 0 and not updated. Message lock, timeout and gap are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single source, 1-byte message:
  - Stimulus: req[1]=1, req_data[1]=8'h41, req_last[1]=1, tx_ready held 1.
  - Response: tx_valid and tx_data=8'h41 one cycle later; handshake; req_ack[1] pulse; busy falls; rr_ptr=2.
- Three-byte message "ABC" (8'h41,8'h42,8'h43) from source 0, with source 2 requesting throughout:
  - Response: bytes go out in order with no interleaving; source 2 wins next.
  - Backpressure: tx_ready=0 for 5 cycles holds tx_data steady.
- Round-robin:
  - Stimulus: all three sources send 1-byte messages continuously from reset.
  - Response: grant_id sequence 0,1,2,0,1,2.
  - With UART_TX_ARB_FIXED_PRIO_EN defined: 0,0,0 while req[0] stays high.
- Timeout:
  - Stimulus: source 1 sends a non-last byte, then drops req; TIMEOUT_CYC=16.
  - Response: abort pulse 16 cycles into NEXT; state IDLE; a pending source 2 is granted next.
- Reset in SEND:
  - Stimulus: assert reset while tx_valid=1 and tx_ready=0.
  - Response: tx_valid=0 and busy=0 immediately (asynchronous), no req_ack; after release, rr_ptr=0.
- GAP_CYC=3:
  - Response: exactly 3 busy idle cycles between the last-byte handshake and the next tx_valid.
